// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared FSM encoding and default operand width for the sequential multiplier
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/twos_negate.sv
// twos_negate: combinational two's-complement negation of a W-bit value
module twos_negate #(
    parameter int W = 8
) (
    input  logic [W-1:0] in_val,
    output logic [W-1:0] out_val
);

    assign out_val = ~in_val + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier processing one multiplier bit per cycle, signed or unsigned
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   result,
    output logic               overflow,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state, next;
    logic [2*WIDTH-1:0] mcand, acc, acc_neg, prod_final;
    logic [WIDTH-1:0]   mplier, a_neg, b_neg, mag_a, mag_b;
    logic [CW-1:0]      cnt;
    logic               sign_r, mode_r, load, ovf;
    logic [WIDTH:0]     hi_signed;

    twos_negate #(.W(WIDTH))   u_neg_a   (.in_val(a),   .out_val(a_neg));
    twos_negate #(.W(WIDTH))   u_neg_b   (.in_val(b),   .out_val(b_neg));
    twos_negate #(.W(2*WIDTH)) u_neg_acc (.in_val(acc), .out_val(acc_neg));

    // Magnitudes: the most negative value negates to itself, which reads correctly as unsigned
    assign mag_a      = (signed_mode && a[WIDTH-1]) ? a_neg : a;
    assign mag_b      = (signed_mode && b[WIDTH-1]) ? b_neg : b;
    assign load       = start && (state != CALC);
    assign prod_final = sign_r ? acc_neg : acc;
    assign hi_signed  = prod_final[2*WIDTH-1:WIDTH-1];
    assign ovf        = mode_r ? !((&hi_signed) || !(|hi_signed)) : |prod_final[2*WIDTH-1:WIDTH];
    assign result     = product[WIDTH-1:0];

    // State register; reset drops straight back to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // Next state and status outputs; CALC spends one extra cycle after the last bit to publish
    always_comb begin
        next = state;
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE: next = start ? CALC : IDLE;
            CALC: begin
                busy = 1'b1;
                next = (cnt == CW'(WIDTH)) ? FIN : CALC;
            end
            FIN: begin
                done = 1'b1;
                next = start ? CALC : IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Operand latch, shift-and-add accumulation, and result publication on entry to FIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign_r   <= 1'b0;
            mode_r   <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            mcand    <= {{WIDTH{1'b0}}, mag_a};
            mplier   <= mag_b;
            acc      <= '0;
            cnt      <= '0;
            sign_r   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            mode_r   <= signed_mode;
        end else if (state == CALC) begin
            if (cnt != CW'(WIDTH)) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end else begin
                product  <= prod_final;
                overflow <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random checks of seq_multiplier at widths 8 and 16
module tb_seq_multiplier;

    logic        clk, rst_n;
    logic        st8, sm8, st16, sm16;
    logic [7:0]  a8, b8, r8;
    logic [15:0] a16, b16, p8, r16;
    logic [31:0] p16;
    logic        ov8, busy8, done8, ov16, busy16, done16;

    int passed = 0, failed = 0, total = 0;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .signed_mode(sm8),
        .product(p8), .result(r8), .overflow(ov8), .busy(busy8), .done(done8)
    );

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16), .signed_mode(sm16),
        .product(p16), .result(r16), .overflow(ov16), .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands as integers, multiply, and test whether the low half represents it
    function automatic void model(input int w, input logic [31:0] ia, input logic [31:0] ib,
                                  input logic sm, output logic [63:0] p, output logic ov);
        longint av, bv, pf, lim;
        av = longint'(ia);
        bv = longint'(ib);
        if (sm && ia[w-1]) av = av - (longint'(1) << w);
        if (sm && ib[w-1]) bv = bv - (longint'(1) << w);
        pf  = av * bv;
        p   = 64'(pf) & ((64'd1 << (2*w)) - 64'd1);
        lim = longint'(1) << (w-1);
        ov  = sm ? (pf < -lim || pf >= lim) : (pf >= (longint'(1) << w));
    endfunction

    function automatic logic [63:0] prod_of(input int w);
        return (w == 8) ? 64'(p8) : 64'(p16);
    endfunction

    function automatic logic [63:0] res_of(input int w);
        return (w == 8) ? 64'(r8) : 64'(r16);
    endfunction

    function automatic logic ov_of(input int w);
        return (w == 8) ? ov8 : ov16;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 8) ? done8 : done16;
    endfunction

    // One complete multiply: start for one cycle, scramble inputs afterwards, check latency and results
    task automatic op(input int w, input logic [31:0] ia, input logic [31:0] ib, input logic sm, input string tag);
        logic [63:0] ep, prev;
        logic        eo;
        int          n;
        model(w, ia, ib, sm, ep, eo);
        @(negedge clk);
        prev = prod_of(w);
        if (w == 8) begin a8 = ia[7:0]; b8 = ib[7:0]; sm8 = sm; st8 = 1'b1; end
        else begin a16 = ia[15:0]; b16 = ib[15:0]; sm16 = sm; st16 = 1'b1; end
        @(posedge clk);
        #1;
        st8 = 1'b0; st16 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
        check({tag, ":busy"}, 64'(busy_of(w)), 64'd1);
        n = 0;
        while (!done_of(w) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 4) check({tag, ":hold"}, prod_of(w), prev);
        end
        check({tag, ":latency"}, 64'(n), 64'(w + 1));
        check({tag, ":product"}, prod_of(w), ep);
        check({tag, ":result"}, res_of(w), ep & ((64'd1 << w) - 64'd1));
        check({tag, ":overflow"}, 64'(ov_of(w)), 64'(eo));
        @(posedge clk);
        #1;
        check({tag, ":done_drop"}, 64'(done_of(w)), 64'd0);
    endtask

    initial begin
        int n, dones, first;
        rst_n = 1'b0;
        st8 = 1'b0; st16 = 1'b0; sm8 = 1'b0; sm16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst:product8", 64'(p8), 64'd0);
        check("rst:overflow8", 64'(ov8), 64'd0);
        check("rst:busy8", 64'(busy8), 64'd0);
        check("rst:done8", 64'(done8), 64'd0);
        check("rst:product16", 64'(p16), 64'd0);
        check("rst:busy16", 64'(busy16), 64'd0);
        #1 rst_n = 1'b1;

        op(8, 5, 3, 1'b0, "5x3");
        check("5x3:abs", 64'(p8), 64'd15);
        op(8, 255, 2, 1'b0, "255x2");
        check("255x2:abs", 64'(p8), 64'd510);
        check("255x2:ov", 64'(ov8), 64'd1);
        op(8, 32'hFF, 2, 1'b1, "m1x2");
        check("m1x2:abs", 64'(p8), 64'hFFFE);
        op(8, 32'h80, 32'h80, 1'b1, "m128sq");
        check("m128sq:abs", 64'(p8), 64'h4000);
        check("m128sq:ov", 64'(ov8), 64'd1);

        @(negedge clk);
        a8 = 8'd12; b8 = 8'd10; sm8 = 1'b0; st8 = 1'b1;
        @(posedge clk);
        #1;
        a8 = 8'd7;
        dones = 0; first = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) st8 = 1'b0;
            if (done8) begin
                dones++;
                if (first == 0) first = i;
            end
        end
        check("ignore:first_done", 64'(first), 64'd9);
        check("ignore:done_count", 64'(dones), 64'd1);
        check("ignore:product", 64'(p8), 64'd120);
        check("ignore:busy", 64'(busy8), 64'd0);

        @(negedge clk);
        a8 = 8'd9; b8 = 8'd9; sm8 = 1'b0; st8 = 1'b1;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort:busy", 64'(busy8), 64'd0);
        check("abort:product", 64'(p8), 64'd0);
        check("abort:done", 64'(done8), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            dones += int'(done8);
        end
        check("abort:no_done", 64'(dones), 64'd0);
        check("abort:product_after", 64'(p8), 64'd0);
        op(8, 0, 50, 1'b0, "0x50");

        op(16, 32'hFED4, 200, 1'b1, "m300x200");
        check("m300x200:abs", 64'(p16), 64'hFFFF15A0);
        check("m300x200:ov", 64'(ov16), 64'd1);

        for (int i = 0; i < 16; i++)
            op(8, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), "rnd8");
        for (int i = 0; i < 6; i++)
            op(16, $urandom_range(0, 65535), $urandom_range(0, 65535), 1'($urandom_range(0, 1)), "rnd16");

        n = passed;
        $display("%0d/%0d checks passed", n, total);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have a parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a request sampled on the rising edge of clk.
REQ-005 The block SHALL have ports a and b, input, WIDTH each, the multiplicand and multiplier.
REQ-006 The block SHALL have port signed_mode, input, 1, selecting the operand interpretation: 1 = two's complement, 0 = unsigned.
REQ-007 The block SHALL have port product, output, 2*WIDTH, the full-width product.
REQ-008 The block SHALL have port result, output, WIDTH, equal to product[WIDTH-1:0].
REQ-009 The block SHALL have port overflow, output, 1, set when result does not represent the true product.
REQ-010 The block SHALL have port busy, output, 1, high while a multiply is in progress.
REQ-011 The block SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-012 The block SHALL use an FSM with three states: IDLE, CALC and FIN.
REQ-013 In IDLE or FIN with start=1, the block SHALL latch a, b and signed_mode, clear the accumulator and the bit counter, and enter CALC.
REQ-014 In signed mode, the block SHALL latch operand magnitudes plus a sign flag equal to the XOR of the two operand MSBs; |-2^(WIDTH-1)| SHALL be handled as an unsigned WIDTH-bit value.
REQ-015 In CALC, each cycle SHALL process one multiplier bit, LSB first: if the bit is 1, add the shifted multiplicand into the 2*WIDTH accumulator, then increment the counter.
REQ-016 After exactly WIDTH CALC cycles, the block SHALL move to FIN.
REQ-017 On the edge that enters FIN, the block SHALL update product to the accumulator, negated (two's complement, 2*WIDTH bits) if the sign flag is set, and SHALL update overflow in the same edge.
REQ-018 Latency: for a start sampled on edge k, done SHALL be high exactly for the cycle following edge k+WIDTH+1.
REQ-019 done SHALL be high only in FIN and SHALL never be high for two consecutive cycles unless a back-to-back start completes.
REQ-020 busy SHALL be high in CALC and low in IDLE and FIN.
REQ-021 The FIN state SHALL return to IDLE when start=0.
REQ-022 product, result and overflow SHALL hold their value until the next FIN; they SHALL NOT change during CALC.
REQ-023 start asserted while in CALC SHALL be ignored, with no effect on the operation in progress.
REQ-024 Input changes on a, b or signed_mode after the start sampling edge SHALL NOT affect the operation in progress.
REQ-025 Unsigned overflow SHALL be defined as product[2W-1:W] != 0.
REQ-026 Signed overflow SHALL be defined as product[2W-1:W-1] being neither all zeros nor all ones.
REQ-027 Either operand equal to 0 SHALL give product=0 and overflow=0 with the same WIDTH+1 latency; there SHALL be no early exit.

Reset
REQ-028 rst_n=0 SHALL force the FSM to IDLE immediately (asynchronously), regardless of the clock.
REQ-029 During reset, product, overflow, busy, done, the accumulator, the counter and the latched operands SHALL all be 0.
REQ-030 Reset asserted mid-CALC SHALL abort the operation; after release, no done pulse SHALL appear and product SHALL remain 0 until a new start completes.
REQ-031 The first start SHALL be accepted on the first rising edge on which rst_n=1.

Structure
REQ-032 The FSM state encoding (IDLE=2'b00, CALC=2'b01, FIN=2'b10) and the default WIDTH constant SHALL live in a shared package named seq_mult_pkg.
REQ-033 Two's-complement negation SHALL be a separate sub-module, twos_negate, parameterised by width; it SHALL be instantiated at WIDTH for operand magnitudes and at 2*WIDTH for the product.
REQ-034 The counter width SHALL be $clog2(WIDTH)+1.

Verification
REQ-035 With WIDTH=8, signed_mode=0, a=5, b=3, start pulsed for one cycle, the bench SHALL check product=15, result=15 and overflow=0, with done exactly 9 edges after the sampling edge.
REQ-036 With WIDTH=8, signed_mode=0, a=255, b=2, the bench SHALL check product=510, result=254 and overflow=1.
REQ-037 With WIDTH=8, signed_mode=1, a=8'hFF (-1) and b=2, the bench SHALL check product=16'hFFFE, result=8'hFE and overflow=0; with a=b=8'h80 (-128), it SHALL check product=16'h4000 and overflow=1.
REQ-038 With WIDTH=8, the bench SHALL start 12*10, then hold start=1 and change a to 7 during CALC, and SHALL check product=120, a single done pulse and the second request ignored.
REQ-039 With WIDTH=8, the bench SHALL start 9*9, pull rst_n low for 3 cycles between clock edges mid-CALC, and SHALL check busy=0, product=0 and no done pulse; 0*50 afterwards SHALL give product=0 and overflow=0.
REQ-040 With WIDTH=16, signed_mode=1, a=-300, b=200, the bench SHALL check product=-60000 (32'hFFFF15A0) and overflow=1, with done 17 edges after the sampling edge.
